// File: rtl/lsu_subword_ctrl.sv
// lsu_subword_ctrl
//   Load/store unit between the execute stage and a word-wide data memory.
//   Byte/half/word requests are turned into whole-word memory accesses:
//   - Loads read the word, select the lane, and sign- or zero-extend it.
//   - Word stores write directly.
//   - Byte/half stores read the word, merge in the new lane, and write it back.
//   Byte order is big-endian: byte lane k sits in bits [31-8k -: 8].
//
// Ports
//   clk, rst          clock and asynchronous active-high reset
//   req_valid/ready   request handshake; ready is high only while idle
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      load zero-extend
//   req_addr          byte address; bits above MEM_ADDR_W are ignored
//   req_wdata         right-aligned store data
//   resp_valid/err    one-cycle completion pulse and its error qualifier
//   rdata             extended load result, held until the next load completes
//   mem_addr          word-aligned memory address
//   mem_wd/mem_we     memory write data and enable
//   mem_rd            combinational memory read data for mem_addr
//
// Build option
//   LSU_ALIGN_CHECK_EN  when defined, misaligned half/word requests complete
//                       with resp_err and no memory access.
module lsu_subword_ctrl #(
   parameter int unsigned MEM_ADDR_W = 10,
   parameter logic [31:0] RDATA_RST  = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [31:0]           rdata,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [31:0]           mem_wd,
   output logic                  mem_we,
   input  logic [31:0]           mem_rd
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LD     = 3'd1;
   localparam logic [2:0] ST_W   = 3'd2;
   localparam logic [2:0] RMW_RD = 3'd3;
   localparam logic [2:0] RMW_WR = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [MEM_ADDR_W-1:0] addr_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [31:0]           wdata_q;
   logic [31:0]           merge_q;
   logic [31:0]           rdata_q;
   logic                  resp_valid_q, resp_err_q;

   logic        accept, req_err;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_val;
   logic [31:0] merged;

   // Request address bits above the memory window are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:MEM_ADDR_W];

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid & req_ready;

`ifdef LSU_ALIGN_CHECK_EN
   assign req_err = (req_size == 2'b11) |
                    ((req_size == 2'b01) & req_addr[0]) |
                    ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
`else
   assign req_err = (req_size == 2'b11);
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept && !req_err) begin
               if (!req_we)                  state_d = LD;
               else if (req_size == 2'b10)   state_d = ST_W;
               else                          state_d = RMW_RD;
            end
         end
         LD, ST_W, RMW_WR: state_d = IDLE;
         RMW_RD:           state_d = RMW_WR;
         default:          state_d = IDLE;
      endcase
   end

   // Lane selection for loads; the memory word is valid while in LD.
   always_comb begin
      ld_byte = 8'h00;
      unique case (addr_q[1:0])
         2'd0: ld_byte = mem_rd[31:24];
         2'd1: ld_byte = mem_rd[23:16];
         2'd2: ld_byte = mem_rd[15:8];
         2'd3: ld_byte = mem_rd[7:0];
         default: ld_byte = 8'h00;
      endcase
      ld_half = addr_q[1] ? mem_rd[15:0] : mem_rd[31:16];
      unique case (size_q)
         2'b00:   ld_val = {{24{~uns_q & ld_byte[7]}}, ld_byte};
         2'b01:   ld_val = {{16{~uns_q & ld_half[15]}}, ld_half};
         default: ld_val = mem_rd;
      endcase
   end

   // Read-modify-write merge: replace only the target lane of the buffered word.
   always_comb begin
      merged = merge_q;
      if (size_q == 2'b00) begin
         unique case (addr_q[1:0])
            2'd0: merged[31:24] = wdata_q[7:0];
            2'd1: merged[23:16] = wdata_q[7:0];
            2'd2: merged[15:8]  = wdata_q[7:0];
            2'd3: merged[7:0]   = wdata_q[7:0];
            default: merged = merge_q;
         endcase
      end else if (addr_q[1]) begin
         merged[15:0] = wdata_q[15:0];
      end else begin
         merged[31:16] = wdata_q[15:0];
      end
   end

   assign mem_addr   = {addr_q[MEM_ADDR_W-1:2], 2'b00};
   // Decoded from state so an asynchronous reset drops the write at once.
   assign mem_we     = (state_q == ST_W) || (state_q == RMW_WR);
   assign mem_wd     = (state_q == ST_W) ? wdata_q : merged;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign rdata      = rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         wdata_q      <= 32'h0;
         merge_q      <= 32'h0;
         rdata_q      <= RDATA_RST;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= (accept & req_err) || (state_q == LD) ||
                         (state_q == ST_W) || (state_q == RMW_WR);
         resp_err_q   <= accept & req_err;
         if (accept && !req_err) begin
            addr_q  <= req_addr[MEM_ADDR_W-1:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
         end
         if (state_q == LD)     rdata_q <= ld_val;
         if (state_q == RMW_RD) merge_q <= mem_rd;
      end
   end

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
module tb_lsu_subword_ctrl;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]    req_size;
   logic [31:0]   req_addr, req_wdata;
   logic          resp_valid, resp_err;
   logic [31:0]   rdata;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wd, mem_rd;
   logic          mem_we;

   always #5 clk = ~clk;

   lsu_subword_ctrl #(.MEM_ADDR_W(AW), .RDATA_RST(32'h0000_0000)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .rdata        (rdata),
      .mem_addr     (mem_addr),
      .mem_wd       (mem_wd),
      .mem_we       (mem_we),
      .mem_rd       (mem_rd)
   );

   // Word memory seen by the DUT.
   logic [31:0] mem [0:255];
   assign mem_rd = mem[mem_addr[AW-1:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[AW-1:2]] <= mem_wd;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, failures = 0;
   int we_cnt = 0, resp_cnt = 0, req_cnt = 0;
   logic [31:0] last_wd = 32'h0;
   logic [31:0] exp_rd;
   int w0;

   typedef struct {
      logic        err;
      logic [31:0] rd;
      int          acc;
      int          lat;   // response edges after accept; -1 = not checked
   } exp_t;
   exp_t sbq[$];
   exp_t popped;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_we) begin
         we_cnt  <= we_cnt + 1;
         last_wd <= mem_wd;
      end
   end

   // Scoreboard: every response pops the oldest expectation.
   always @(negedge clk) begin
      if (resp_valid) begin
         resp_cnt <= resp_cnt + 1;
         if (sbq.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            popped = sbq.pop_front();
            chk("resp_err", {31'd0, resp_err}, {31'd0, popped.err});
            chk("rdata", rdata, popped.rd);
            if (popped.lat >= 0) chk("latency", cyc - popped.acc, popped.lat);
         end
      end
   end

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic err, input logic [31:0] rd, input int lat,
                        input bit push);
      int n = 0;
      exp_t e;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      if (push) begin
         e.err = err; e.rd = rd; e.acc = cyc + 1; e.lat = lat;
         sbq.push_back(e);
         req_cnt++;
      end
      @(posedge clk);
      #1;
      // Scramble request fields after accept; the DUT must have latched them.
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_size  = 2'($urandom_range(0, 3));
   endtask

   task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] exp);
      exp_rd = exp;
      issue(1'b0, sz, uns, a, 32'h0, 1'b0, exp, 1, 1'b1);
   endtask

   task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      issue(1'b1, sz, 1'b0, a, wd, 1'b0, exp_rd, (sz == 2'b10) ? 1 : 2, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      #1;
      chk("drain", sbq.size(), 32'd0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      exp_rd = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      rst = 1'b0;

      // Word store then word load.
      w0 = we_cnt;
      store(2'b10, 32'h10, 32'hDEAD_BEEF);
      drain();
      chk("sw_we_cycles", we_cnt - w0, 32'd1);
      chk("sw_wd", last_wd, 32'hDEAD_BEEF);
      load(2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);

      store(2'b10, 32'h10, 32'h1122_3344);
      store(2'b10, 32'h20, 32'h80FF_7F01);
      store(2'b10, 32'h30, 32'hCAFE_F00D);
      drain();

      // Byte store via read-modify-write.
      w0 = we_cnt;
      store(2'b00, 32'h12, 32'h0000_00AA);
      drain();
      chk("sb_we_cycles", we_cnt - w0, 32'd1);
      chk("sb_merge_wd", last_wd, 32'h1122_AA44);
      load(2'b10, 1'b0, 32'h10, 32'h1122_AA44);
      // Store accepted in the load's response cycle.
      store(2'b00, 32'h13, 32'hFFFF_FF55);
      load(2'b10, 1'b0, 32'h10, 32'h1122_AA55);

      // Extension and lane selection.
      load(2'b00, 1'b0, 32'h20, 32'hFFFF_FF80);
      load(2'b00, 1'b1, 32'h20, 32'h0000_0080);
      load(2'b01, 1'b0, 32'h22, 32'h0000_7F01);
      load(2'b01, 1'b1, 32'h20, 32'h0000_80FF);
      load(2'b00, 1'b0, 32'h21, 32'hFFFF_FFFF);
      load(2'b00, 1'b0, 32'h23, 32'h0000_0001);
      drain();

      // Misaligned half and illegal size.
      w0 = we_cnt;
`ifdef LSU_ALIGN_CHECK_EN
      issue(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b1, exp_rd, -1, 1'b1);
`else
      load(2'b01, 1'b0, 32'h21, 32'hFFFF_80FF);
`endif
      issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b1, exp_rd, -1, 1'b1);
      issue(1'b1, 2'b11, 1'b0, 32'h20, 32'h0, 1'b1, exp_rd, -1, 1'b1);
      drain();
      chk("err_no_write", we_cnt - w0, 32'd0);

      // Request address bits above the memory window are ignored.
      load(2'b10, 1'b0, 32'h8000_0410, 32'h1122_AA55);
      drain();

      // Reset during RMW_RD abandons the store.
      w0 = we_cnt;
      issue(1'b1, 2'b01, 1'b0, 32'h30, 32'h0000_1234, 1'b0, exp_rd, 2, 1'b0);
      rst = 1'b1;
      #2;
      chk("rmw_rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rmw_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rmw_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rmw_rst_rdata", rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      exp_rd = 32'h0;
      repeat (4) @(negedge clk);
      chk("rmw_rst_no_write", we_cnt - w0, 32'd0);
      chk("rmw_rst_word", mem[12], 32'hCAFE_F00D);
      chk("rmw_rst_ready_after", {31'd0, req_ready}, 32'd1);

      // Half store to the low half, then read back.
      store(2'b01, 32'h32, 32'h0000_BEEF);
      load(2'b10, 1'b0, 32'h30, 32'hCAFE_BEEF);
      load(2'b01, 1'b1, 32'h30, 32'h0000_CAFE);
      drain();
      chk("resp_count", resp_cnt, req_cnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
